// File: rtl/fcp6_slave.sv
// fcp6_slave: FCP6 bus target with a 64x8 local memory and a host load/inspect port.
// Bus pins are split into in/out/oe triplets; the tristate merge lives at chip top.
module fcp6_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h2A,
  parameter int unsigned READ_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ctrl_in,
  input  logic [1:0] data_in,
  output logic [1:0] ctrl_out,
  output logic       ctrl_oe,
  output logic [1:0] data_out,
  output logic       data_oe,
  output logic       ack_out,
  output logic       ack_oe,
  input  logic       host_we,
  input  logic [5:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       busy,
  output logic       xfer_done,
  output logic       overflow
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PTR_W = 7;

  localparam logic [1:0] C_IDLE   = 2'b00;
  localparam logic [1:0] C_VALID  = 2'b01;
  localparam logic [1:0] C_SLAVE  = 2'b10;
  localparam logic [1:0] C_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_ACK, S_WRITE, S_READ, S_READ_STOP, S_IGNORE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hdr_q, hdr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [5:0]         wbyte_q, wbyte_d;
  logic               ovf_d, xfer_d, busy_d;
  logic               ack_d, ctrl_oe_d, data_oe_d;
  logic [1:0]         ctrl_out_d, data_out_d;
  logic               mem_we_c;
  logic [7:0]         rd_byte_c;

  logic [7:0] mem [DEPTH];

  function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] i);
    case (i)
      2'd0:    dibit_of = b[1:0];
      2'd1:    dibit_of = b[3:2];
      2'd2:    dibit_of = b[5:4];
      default: dibit_of = b[7:6];
    endcase
  endfunction

  // Next-state, datapath updates and next values for the registered outputs
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wbyte_d    = wbyte_q;
    ovf_d      = overflow;
    xfer_d     = 1'b0;
    mem_we_c   = 1'b0;
    ack_d      = 1'b0;
    ctrl_oe_d  = 1'b0;
    data_oe_d  = 1'b0;
    ctrl_out_d = C_IDLE;
    data_out_d = 2'b00;
    rd_byte_c  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (ctrl_in == C_VALID) begin
          hdr_d   = {6'b0, data_in};
          cnt_d   = 2'd1;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        // Anything but a valid dibit (slave code 10 included) aborts the header
        if (ctrl_in == C_VALID) begin
          hdr_d = {hdr_q[5:0], data_in};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (hdr_d[7:1] == SLAVE_ADDR) begin
              state_d = S_ACK;
              ptr_d   = '0;
              cnt_d   = 2'd0;
              ovf_d   = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        state_d = hdr_q[0] ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        if (ctrl_in == C_STOP) begin
          state_d = S_IDLE;
          xfer_d  = 1'b1;
        end else if (ctrl_in == C_VALID) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    wbyte_d[1:0] = data_in;
            2'd1:    wbyte_d[3:2] = data_in;
            2'd2:    wbyte_d[5:4] = data_in;
            default: begin
              // Full byte: store while there is room, otherwise flag the drop
              if (!ptr_q[PTR_W-1]) begin
                mem_we_c = 1'b1;
                ptr_d    = ptr_q + PTR_W'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          endcase
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (ptr_q + PTR_W'(1) == PTR_W'(READ_BYTES)) state_d = S_READ_STOP;
          else                                         ptr_d   = ptr_q + PTR_W'(1);
        end
      end
      S_READ_STOP: begin
        state_d = S_IDLE;
        xfer_d  = 1'b1;
      end
      S_IGNORE: begin
        if (ctrl_in == C_STOP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output values for the state being entered
    case (state_d)
      S_ACK: ack_d = 1'b1;
      S_READ: begin
        rd_byte_c  = mem[ptr_d[5:0]];
        ctrl_oe_d  = 1'b1;
        data_oe_d  = 1'b1;
        ctrl_out_d = C_SLAVE;
        data_out_d = dibit_of(rd_byte_c, cnt_d);
      end
      S_READ_STOP: begin
        ctrl_oe_d  = 1'b1;
        data_oe_d  = 1'b1;
        ctrl_out_d = C_STOP;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers; reset releases all drivers at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hdr_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wbyte_q   <= '0;
      overflow  <= 1'b0;
      xfer_done <= 1'b0;
      busy      <= 1'b0;
      ack_out   <= 1'b0;
      ack_oe    <= 1'b0;
      ctrl_oe   <= 1'b0;
      data_oe   <= 1'b0;
      ctrl_out  <= 2'b00;
      data_out  <= 2'b00;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wbyte_q   <= wbyte_d;
      overflow  <= ovf_d;
      xfer_done <= xfer_d;
      busy      <= busy_d;
      ack_out   <= ack_d;
      ack_oe    <= ack_d;
      ctrl_oe   <= ctrl_oe_d;
      data_oe   <= data_oe_d;
      ctrl_out  <= ctrl_out_d;
      data_out  <= data_out_d;
    end
  end

  // Memory array; the bus write is applied last so it wins an address collision
  always_ff @(posedge clk) begin
    if (host_we)  mem[host_addr]   <= host_wdata;
    if (mem_we_c) mem[ptr_q[5:0]]  <= {data_in, wbyte_q};
  end

  // Host readback, pre-write value on a same-cycle read/write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= 8'h00;
    else     host_rdata <= mem[host_addr];
  end

endmodule

// File: tb/tb_fcp6_slave.sv
// tb_fcp6_slave: directed self-checking bench for fcp6_slave.
module tb_fcp6_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ctrl_in, data_in;
  logic [1:0] ctrl_out, data_out;
  logic       ctrl_oe, data_oe, ack_out, ack_oe;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       busy, xfer_done, overflow;

  int ntests = 0;
  int nfail  = 0;

  fcp6_slave #(.SLAVE_ADDR(7'h2A), .READ_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .ctrl_in(ctrl_in), .data_in(data_in),
    .ctrl_out(ctrl_out), .ctrl_oe(ctrl_oe),
    .data_out(data_out), .data_oe(data_oe),
    .ack_out(ack_out), .ack_oe(ack_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .busy(busy), .xfer_done(xfer_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Expected read dibits for bytes 11,22,33,44 sent LSB-first
  logic [1:0] rd_exp [16] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0,
                              2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dib(input logic [1:0] c, input logic [1:0] d);
    ctrl_in = c;
    data_in = d;
    tick();
  endtask

  task automatic send_hdr(input logic [7:0] h);
    dib(2'b01, h[7:6]);
    dib(2'b01, h[5:4]);
    dib(2'b01, h[3:2]);
    dib(2'b01, h[1:0]);
    ctrl_in = 2'b00;
    data_in = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dib(2'b01, b[1:0]);
    dib(2'b01, b[3:2]);
    dib(2'b01, b[5:4]);
    dib(2'b01, b[7:6]);
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    host_addr = a;
    tick();
    chk(tag, host_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; ctrl_in = 2'b00; data_in = 2'b00;
    host_we = 1'b0; host_addr = 6'd0; host_wdata = 8'h00;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ack_oe", ack_oe, 0);
    chk("rst_ctrl_oe", ctrl_oe, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_host_rdata", host_rdata, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Write A5, 3C to addr 2A; host writes 99 to addr 0 while the bus byte lands there
    send_hdr(8'h55);
    chk("wr_ack_oe", ack_oe, 1);
    chk("wr_ack_out", ack_out, 1);
    chk("wr_busy", busy, 1);
    dib(2'b00, 2'b00);
    chk("wr_ack_one_cycle", ack_oe, 0);
    host_we = 1'b1; host_addr = 6'd0; host_wdata = 8'h99;
    send_byte(8'hA5);
    host_we = 1'b0;
    send_byte(8'h3C);
    dib(2'b11, 2'b00);
    chk("wr_xfer_done", xfer_done, 1);
    chk("wr_busy_end", busy, 0);
    dib(2'b00, 2'b00);
    chk("wr_xfer_pulse", xfer_done, 0);
    host_chk("wr_mem0", 6'd0, 8'hA5);
    host_chk("wr_mem1", 6'd1, 8'h3C);

    // Host same-cycle read/write shows the old value first
    host_wr(6'd5, 8'h12);
    host_wdata = 8'h34; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    chk("host_prewrite", host_rdata, 8'h12);
    tick();
    chk("host_postwrite", host_rdata, 8'h34);

    // Read of 4 preloaded bytes
    host_wr(6'd0, 8'h11);
    host_wr(6'd1, 8'h22);
    host_wr(6'd2, 8'h33);
    host_wr(6'd3, 8'h44);
    send_hdr(8'h54);
    chk("rd_ack_oe", ack_oe, 1);
    chk("rd_ctrl_oe_in_ack", ctrl_oe, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rd_ctrl_out_%0d", i), ctrl_out, 2'b10);
      chk($sformatf("rd_data_oe_%0d", i), data_oe, 1);
      chk($sformatf("rd_data_%0d", i), data_out, rd_exp[i]);
      tick();
    end
    chk("rd_stop_ctrl", ctrl_out, 2'b11);
    chk("rd_stop_data", data_out, 2'b00);
    chk("rd_stop_oe", ctrl_oe, 1);
    tick();
    chk("rd_end_ctrl_oe", ctrl_oe, 0);
    chk("rd_end_data_oe", data_oe, 0);
    chk("rd_end_xfer", xfer_done, 1);
    chk("rd_end_busy", busy, 0);

    // Non-matching header 0x57 is ignored until stop
    send_hdr(8'h57);
    chk("ign_ack_oe", ack_oe, 0);
    chk("ign_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      dib(2'b00, 2'b00);
      chk("ign_ack_oe_wait", ack_oe, 0);
      chk("ign_ctrl_oe_wait", ctrl_oe, 0);
    end
    dib(2'b11, 2'b00);
    chk("ign_busy_end", busy, 0);
    chk("ign_no_xfer", xfer_done, 0);

    // Header aborted after 2 dibits, then a normal header
    dib(2'b01, 2'b01);
    dib(2'b01, 2'b01);
    chk("abort_busy_mid", busy, 1);
    dib(2'b00, 2'b00);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack_oe, 0);
    send_hdr(8'h55);
    chk("abort_then_ack", ack_oe, 1);
    dib(2'b00, 2'b00);
    dib(2'b11, 2'b00);
    chk("abort_then_xfer", xfer_done, 1);
    dib(2'b00, 2'b00);

    // Reset during the read data phase
    send_hdr(8'h54);
    tick();
    tick();
    tick();
    chk("rstmid_ctrl_oe_before", ctrl_oe, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ctrl_oe", ctrl_oe, 0);
    chk("rstmid_data_oe", data_oe, 0);
    chk("rstmid_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_no_xfer", xfer_done, 0);
    send_hdr(8'h54);
    chk("rstmid_ack", ack_oe, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstmid_data_%0d", i), data_out, rd_exp[i]);
      tick();
    end
    for (int i = 0; i < 13; i++) tick();
    chk("rstmid_end_oe", ctrl_oe, 0);

    // 65-byte write: 64 x FF then 00 which must be dropped
    send_hdr(8'h55);
    dib(2'b00, 2'b00);
    for (int i = 0; i < 64; i++) send_byte(8'hFF);
    chk("ovf_before", overflow, 0);
    send_byte(8'h00);
    chk("ovf_set", overflow, 1);
    dib(2'b11, 2'b00);
    chk("ovf_sticky", overflow, 1);
    dib(2'b00, 2'b00);
    host_chk("ovf_mem0", 6'd0, 8'hFF);
    host_chk("ovf_mem1", 6'd1, 8'hFF);
    host_chk("ovf_mem63", 6'd63, 8'hFF);
    send_hdr(8'h55);
    chk("ovf_clear_ack", ack_oe, 1);
    chk("ovf_cleared", overflow, 0);
    dib(2'b00, 2'b00);
    dib(2'b11, 2'b00);
    dib(2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
